// File: rtl/instr_fetch.sv
// Purpose : instruction-fetch stage; holds the PC, fetches 32-bit words over a req/ack
//           handshake, registers the word and slices it into datapath fields.
// Latency : min 2 cycles/instruction (FETCH with same-cycle ack, then ISSUE).
// Backpr. : imem_req held until imem_ack; stall holds the issued instruction in ISSUE.
//
// Ports
//   clk, reset_n           clock, asynchronous active-low reset
//   imem_req/addr          fetch request (level) and address (= PC)
//   imem_ack/rdata         memory response, accepted only while imem_req=1
//   instr, instr_valid     registered instruction and its valid flag
//   pc_out                 address of the issued instruction
//   stall                  hold the issued instruction (ignore take_br)
//   take_br, br_sel        redirect to PC-relative target; 0=CondAddr19, 1=BrAddr26
//   Rd/Rn/Rm/DAddr9/Imm12  combinational slices of instr
module instr_fetch #(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc_out,
  input  logic              stall,
  input  logic              take_br,
  input  logic              br_sel,
  output logic [4:0]        Rd,
  output logic [4:0]        Rn,
  output logic [4:0]        Rm,
  output logic [8:0]        DAddr9,
  output logic [11:0]       Imm12
);

  typedef enum logic {FETCH, ISSUE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] off_se;
  logic [ADDR_W-1:0] next_pc;

  // Sign-extend the selected word offset to the full PC width, then scale by 4.
  always_comb begin
    off_se = '0;
    if (br_sel)
      off_se = {{(ADDR_W-26){instr[25]}}, instr[25:0]};
    else
      off_se = {{(ADDR_W-19){instr[23]}}, instr[23:5]};
  end

  // Both paths wrap modulo 2^ADDR_W with no flag.
  assign next_pc = take_br ? (pc + {off_se[ADDR_W-3:0], 2'b00})
                           : (pc + ADDR_W'(4));

  // imem_req is a registered output: it stays low for the first cycle after reset
  // release, so any ack arriving in that cycle is ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_req && imem_ack) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            state       <= ISSUE;
          end else begin
            imem_req    <= 1'b1;
          end
        end
        ISSUE: begin
          // Retire: redirect or advance, then immediately request the next word.
          if (!stall) begin
            pc          <= next_pc;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            state       <= FETCH;
          end
        end
        default: begin
          state       <= FETCH;
          instr_valid <= 1'b0;
          imem_req    <= 1'b0;
        end
      endcase
    end
  end

  assign imem_addr = pc;
  assign pc_out    = pc;

  assign Rd     = instr[4:0];
  assign Rn     = instr[9:5];
  assign Rm     = instr[20:16];
  assign DAddr9 = instr[20:12];
  assign Imm12  = instr[21:10];

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  logic        clk;
  logic        reset_n;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [63:0] pc_out;
  logic        stall;
  logic        take_br;
  logic        br_sel;
  logic [4:0]  Rd, Rn, Rm;
  logic [8:0]  DAddr9;
  logic [11:0] Imm12;

  int passed = 0;
  int total  = 0;
  logic [63:0] exp_pc;

  instr_fetch #(.ADDR_W(64), .RESET_PC(64'h0)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .pc_out(pc_out),
    .stall(stall), .take_br(take_br), .br_sel(br_sel),
    .Rd(Rd), .Rn(Rn), .Rm(Rm), .DAddr9(DAddr9), .Imm12(Imm12)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference: branch offset as a signed integer in words, times 4, added modulo 2^64.
  function automatic logic [63:0] model_next(input logic [63:0] pc, input logic [31:0] w,
                                             input bit take, input bit sel);
    longint off;
    if (!take) return pc + 64'd4;
    if (sel) begin
      off = longint'(w & 32'h03FF_FFFF);
      if (off >= 64'sd33554432) off = off - 64'sd67108864;
    end else begin
      off = longint'((w >> 5) & 32'h0007_FFFF);
      if (off >= 64'sd262144) off = off - 64'sd524288;
    end
    return pc + 64'(off * 4);
  endfunction

  function automatic logic [31:0] b_word(input logic [25:0] off26);
    return 32'h1400_0000 | {6'd0, off26};
  endfunction

  task automatic reset_dut;
    reset_n  = 1'b0;
    imem_ack = 1'b0;
    stall    = 1'b0;
    take_br  = 1'b0;
    br_sel   = 1'b0;
    tick;
    tick;
    reset_n  = 1'b1;
    exp_pc   = 64'h0;
  endtask

  // Fetch one word (after 'delay' unacked cycles), hold it 'nstall' cycles, then retire.
  task automatic issue(input logic [31:0] w, input int delay, input int nstall,
                       input bit take, input bit sel);
    int t;
    t = 0;
    while (imem_req !== 1'b1 && t < 10) begin tick; t++; end
    total++;
    if (imem_req !== 1'b1) begin
      $display("FAIL req_timeout: imem_req=%b required 1", imem_req);
      return;
    end
    passed++;
    for (int i = 0; i <= delay; i++) begin
      total++;
      if (imem_req !== 1'b1 || imem_addr !== exp_pc || instr_valid !== 1'b0)
        $display("FAIL fetch_hold: req=%b addr=%h valid=%b required 1/%h/0",
                 imem_req, imem_addr, instr_valid, exp_pc);
      else passed++;
      imem_rdata = (i == delay) ? w : $urandom;
      imem_ack   = (i == delay);
      tick;
    end
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    total++;
    if (instr_valid !== 1'b1 || instr !== w || pc_out !== exp_pc || imem_req !== 1'b0)
      $display("FAIL issue: valid=%b instr=%h pc_out=%h req=%b required 1/%h/%h/0",
               instr_valid, instr, pc_out, imem_req, w, exp_pc);
    else passed++;
    total++;
    if (Rd !== 5'(w % 32) || Rn !== 5'((w / 32) % 32) || Rm !== 5'((w / 65536) % 32) ||
        DAddr9 !== 9'((w / 4096) % 512) || Imm12 !== 12'((w / 1024) % 4096))
      $display("FAIL fields: Rd=%h Rn=%h Rm=%h DAddr9=%h Imm12=%h for word %h",
               Rd, Rn, Rm, DAddr9, Imm12, w);
    else passed++;
    for (int s = 0; s < nstall; s++) begin
      stall    = 1'b1;
      take_br  = 1'($urandom);
      br_sel   = 1'($urandom);
      imem_ack = 1'($urandom);
      imem_rdata = $urandom;
      tick;
      total++;
      if (instr !== w || pc_out !== exp_pc || instr_valid !== 1'b1 || imem_req !== 1'b0)
        $display("FAIL stall_hold: instr=%h pc_out=%h valid=%b req=%b required %h/%h/1/0",
                 instr, pc_out, instr_valid, imem_req, w, exp_pc);
      else passed++;
    end
    imem_ack = 1'b0;
    stall    = 1'b0;
    take_br  = take;
    br_sel   = sel;
    tick;
    exp_pc  = model_next(exp_pc, w, take, sel);
    take_br = 1'b0;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== exp_pc || instr_valid !== 1'b0)
      $display("FAIL retire: req=%b addr=%h valid=%b required 1/%h/0",
               imem_req, imem_addr, instr_valid, exp_pc);
    else passed++;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; imem_ack = 1'b0; stall = 1'b0; take_br = 1'b0; br_sel = 1'b0;
    imem_rdata = 32'h0;
    tick;
    tick;
    total++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0 ||
        imem_addr !== 64'h0 || pc_out !== 64'h0 || Rd !== 5'd0 || Imm12 !== 12'd0)
      $display("FAIL reset_state: req=%b valid=%b instr=%h addr=%h required 0/0/0/0",
               imem_req, instr_valid, instr, imem_addr);
    else passed++;
    reset_n    = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    total++;
    if (imem_req !== 1'b0)
      $display("FAIL req_after_release: imem_req=%b required 0", imem_req);
    else passed++;
    tick;
    total++;
    if (imem_req !== 1'b1 || instr !== 32'h0 || instr_valid !== 1'b0)
      $display("FAIL first_req: req=%b instr=%h valid=%b required 1/0/0",
               imem_req, instr, instr_valid);
    else passed++;
    imem_ack = 1'b0;
  endtask

  task automatic test_ack_tied;
    logic [31:0] w;
    reset_dut;
    imem_ack   = 1'b1;
    imem_rdata = $urandom;
    w = 32'h0;
    tick;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (i % 2 == 0) begin
        if (imem_req !== 1'b1 || instr_valid !== 1'b0 || imem_addr !== exp_pc)
          $display("FAIL tied_fetch[%0d]: req=%b valid=%b addr=%h required 1/0/%h",
                   i, imem_req, instr_valid, imem_addr, exp_pc);
        else passed++;
        imem_rdata = $urandom;
        w = imem_rdata;
      end else begin
        if (instr_valid !== 1'b1 || instr !== w || pc_out !== exp_pc ||
            Rd !== 5'(w % 32) || Rn !== 5'((w / 32) % 32) || Rm !== 5'((w / 65536) % 32))
          $display("FAIL tied_issue[%0d]: valid=%b instr=%h pc_out=%h required 1/%h/%h",
                   i, instr_valid, instr, pc_out, w, exp_pc);
        else passed++;
        exp_pc = exp_pc + 64'd4;
      end
      tick;
    end
    imem_ack = 1'b0;
  endtask

  task automatic test_branch_back;
    reset_dut;
    issue(b_word(26'd16), 0, 0, 1'b1, 1'b1);
    total++;
    if (imem_addr !== 64'h40) $display("FAIL b_to_40: addr=%h required 40", imem_addr);
    else passed++;
    issue(b_word(26'h3FF_FFFC), 0, 0, 1'b1, 1'b1);
    total++;
    if (imem_addr !== 64'h30) $display("FAIL b_minus4: addr=%h required 30", imem_addr);
    else passed++;
  endtask

  task automatic test_cbz;
    logic [31:0] cbz;
    cbz = 32'hB400_0000 | (32'd3 << 5);
    for (int r = 0; r < 2; r++) begin
      reset_dut;
      issue(b_word(26'd4), 0, 0, 1'b1, 1'b1);
      issue(cbz, 0, 0, r[0], 1'b0);
      total++;
      if (imem_addr !== (r == 0 ? 64'h14 : 64'h1C))
        $display("FAIL cbz[%0d]: addr=%h required %h", r, imem_addr,
                 (r == 0 ? 64'h14 : 64'h1C));
      else passed++;
    end
  endtask

  task automatic test_delay_stall;
    logic [63:0] base;
    reset_dut;
    base = exp_pc;
    issue(b_word(26'd100), 3, 5, 1'b0, 1'b1);
    total++;
    if (imem_addr !== base + 64'd4)
      $display("FAIL stall_no_branch: addr=%h required %h", imem_addr, base + 64'd4);
    else passed++;
  endtask

  task automatic test_reset_mid_fetch;
    reset_dut;
    issue(b_word(26'd32), 0, 0, 1'b1, 1'b1);
    tick;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h80)
      $display("FAIL pre_reset: req=%b addr=%h required 1/80", imem_req, imem_addr);
    else passed++;
    reset_n = 1'b0;
    #1;
    total++;
    if (imem_req !== 1'b0) $display("FAIL async_drop: req=%b required 0", imem_req);
    else passed++;
    imem_ack   = 1'b1;
    imem_rdata = 32'hCAFE_F00D;
    tick;
    total++;
    if (instr !== 32'h0 || imem_req !== 1'b0 || instr_valid !== 1'b0 || imem_addr !== 64'h0)
      $display("FAIL stray_ack_in_reset: instr=%h req=%b valid=%b addr=%h required 0/0/0/0",
               instr, imem_req, instr_valid, imem_addr);
    else passed++;
    reset_n = 1'b1;
    exp_pc  = 64'h0;
    tick;
    total++;
    if (instr !== 32'h0 || imem_req !== 1'b1 || imem_addr !== 64'h0 || instr_valid !== 1'b0)
      $display("FAIL late_ack: instr=%h req=%b addr=%h valid=%b required 0/1/0/0",
               instr, imem_req, imem_addr, instr_valid);
    else passed++;
    imem_ack = 1'b0;
    issue($urandom, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_wrap;
    reset_dut;
    issue(b_word(26'h3FF_FFFF), 0, 0, 1'b1, 1'b1);
    total++;
    if (imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC)
      $display("FAIL wrap_below0: addr=%h required fffffffffffffffc", imem_addr);
    else passed++;
    issue($urandom, 1, 0, 1'b0, 1'b0);
    total++;
    if (imem_addr !== 64'h0) $display("FAIL wrap_top: addr=%h required 0", imem_addr);
    else passed++;
  endtask

  task automatic test_random;
    reset_dut;
    for (int n = 0; n < 40; n++)
      issue($urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            1'($urandom), 1'($urandom));
  endtask

  initial begin
    test_reset;
    test_ack_tied;
    test_branch_back;
    test_cbz;
    test_delay_stall;
    test_reset_mid_fetch;
    test_wrap;
    test_random;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
